// File: rtl/dct_pkg.sv
// Shared definitions for the streaming 8x8 DCT: coefficient table, fixed-point
// rounding/saturation helper and the per-bank buffer state.
package dct_pkg;

  localparam int unsigned COEF_W    = 8;
  localparam int unsigned COEF_FRAC = 7;

  // R[k][j] = round(128 * c_k * cos((2j+1) k pi / 16))
  localparam logic signed [COEF_W-1:0] DCT_C [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_e;

  // Round half up, floor shift by frac, then clamp to a signed out_w range.
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] acc,
                                                   input int unsigned frac,
                                                   input int unsigned out_w);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (acc + (32'sd1 <<< (frac - 1))) >>> frac;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_mac8.sv
// One DCT basis row: 8-term signed dot product against DCT_C[K], rounded and
// saturated to OUT_W.
module dct_mac8 import dct_pkg::*; #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned CW    = COEF_W,
  parameter int unsigned OUT_W = 11,
  parameter int unsigned FRAC  = COEF_FRAC,
  parameter int unsigned K     = 0
) (
  input  logic [8*IN_W-1:0] x,
  output logic [OUT_W-1:0]  y
);

  localparam int unsigned ACC_W = IN_W + CW + 3;

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < 8; j++) begin
      acc = acc + ACC_W'(signed'(x[j*IN_W +: IN_W])) * ACC_W'(CW'(DCT_C[K][j]));
    end
  end

  assign y = OUT_W'(round_sat(32'(acc), FRAC, OUT_W));

endmodule

// File: rtl/dct2d_stream.sv
// Streaming 8x8 2-D DCT: row pass into a ping-pong transpose buffer, column
// pass out one coefficient column per beat. Optional macro: DCT_LEVEL_SHIFT_EN.
module dct2d_stream import dct_pkg::*; #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = dct_pkg::COEF_W,
  parameter int unsigned COEF_FRAC = dct_pkg::COEF_FRAC,
  parameter int unsigned MID_W     = 11,
  parameter int unsigned OUT_W     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0][DATA_W-1:0] in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0][OUT_W-1:0]  out_col,
  output logic [2:0]             out_idx,
  output logic                   out_last
);

`ifdef DCT_LEVEL_SHIFT_EN
  localparam int unsigned SAMP_W = DATA_W + 1;
`else
  localparam int unsigned SAMP_W = DATA_W;
`endif

  logic [7:0][SAMP_W-1:0] samp;
  logic [7:0][MID_W-1:0]  row_t;
  logic [7:0][MID_W-1:0]  col_t;
  logic [7:0][OUT_W-1:0]  col_y;
  logic [7:0][MID_W-1:0]  buf_mem [2][8];

  bank_st_e   bank_st [2];
  logic [1:0] full;
  logic       wbank;
  logic       rbank;
  logic [2:0] wr_r;
  logic [2:0] rd_c;
  logic       accept;
  logic       load;

  // Input sample conditioning ahead of the row pass.
  always_comb begin
    samp = '0;
    for (int j = 0; j < 8; j++) begin
`ifdef DCT_LEVEL_SHIFT_EN
      samp[j] = SAMP_W'({1'b0, in_row[j]}) - SAMP_W'(1 << (DATA_W - 1));
`else
      samp[j] = in_row[j];
`endif
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_row
    dct_mac8 #(
      .IN_W (SAMP_W),
      .CW   (COEF_W),
      .OUT_W(MID_W),
      .FRAC (COEF_FRAC),
      .K    (k)
    ) u_mac (
      .x(samp),
      .y(row_t[k])
    );
  end

  always_comb begin
    full = '0;
    for (int b = 0; b < 2; b++) begin
      full[b] = (bank_st[b] == BANK_FULL) || (bank_st[b] == BANK_DRAINING);
    end
  end

  assign in_ready = rst & ~full[wbank];
  assign accept   = in_valid & in_ready;
  assign load     = full[rbank] & (~out_valid | out_ready);

  // Transpose buffer: one row-pass result per accepted beat; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wbank][wr_r] <= row_t;
    end
  end

  // Column rd_c of the bank being drained feeds the column pass.
  always_comb begin
    col_t = '0;
    for (int r = 0; r < 8; r++) begin
      col_t[r] = buf_mem[rbank][r][rd_c];
    end
  end

  for (genvar m = 0; m < 8; m++) begin : g_col
    dct_mac8 #(
      .IN_W (MID_W),
      .CW   (COEF_W),
      .OUT_W(OUT_W),
      .FRAC (COEF_FRAC),
      .K    (m)
    ) u_mac (
      .x(col_t),
      .y(col_y[m])
    );
  end

  // Per-bank lifecycle; the write and read sides always address different banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wr_r       <= '0;
      rd_c       <= '0;
    end else begin
      if (accept) begin
        wr_r <= wr_r + 3'd1;
        if (wr_r == 3'd7) begin
          bank_st[wbank] <= BANK_FULL;
          wbank          <= ~wbank;
        end else if (wr_r == 3'd0) begin
          bank_st[wbank] <= BANK_FILLING;
        end
      end
      if (load) begin
        rd_c <= rd_c + 3'd1;
        if (rd_c == 3'd7) begin
          bank_st[rbank] <= BANK_EMPTY;
          rbank          <= ~rbank;
        end else if (rd_c == 3'd0) begin
          bank_st[rbank] <= BANK_DRAINING;
        end
      end
    end
  end

  // Output register holds its column until the downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_col   <= col_y;
      out_idx   <= rd_c;
      out_last  <= (rd_c == 3'd7);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct2d_stream.sv
// Self-checking bench for dct2d_stream: directed vector table, back-pressure
// and reset sequences, and a randomized stream against a real-valued DCT model.
module tb_dct2d_stream;

  typedef logic signed [7:0][7:0][7:0]  blk_t;
  typedef logic signed [7:0][7:0][11:0] res_t;
  typedef struct {
    string name;
    blk_t  x;
    res_t  y;
  } vec_t;

  localparam real PI = 3.14159265358979;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [7:0][7:0]  in_row;
  logic             out_valid;
  logic             out_ready;
  logic [7:0][11:0] out_col;
  logic [2:0]       out_idx;
  logic             out_last;

  dct2d_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col  (out_col),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   rows_acc = 0;
  int   rc [8][8];
  res_t cap;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Coefficients straight from the cosine definition.
  function automatic void init_coefs();
    real ck;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
      for (int j = 0; j < 8; j++) begin
        rc[k][j] = int'(128.0 * ck * $cos(real'((2 * j + 1) * k) * PI / 16.0));
      end
    end
  endfunction

  function automatic int rs(input longint a, input int w);
    longint v, q, lim;
    v = a + 64;
    q = v / 128;
    if ((v % 128) != 0 && v < 0) q = q - 1;
    lim = longint'(1) << (w - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
    return int'(q);
  endfunction

  // y[c][m] = Y[m][c] with Y = R * X * R'
  function automatic res_t ref_dct(input blk_t x);
    int     t [8][8];
    longint s;
    res_t   y;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        s = 0;
        for (int j = 0; j < 8; j++) s += longint'($signed(x[r][j])) * rc[k][j];
        t[r][k] = rs(s, 11);
      end
    for (int c = 0; c < 8; c++)
      for (int m = 0; m < 8; m++) begin
        s = 0;
        for (int r = 0; r < 8; r++) s += longint'(rc[m][r]) * t[r][c];
        y[c][m] = 12'(rs(s, 12));
      end
    return y;
  endfunction

  function automatic blk_t rand_blk();
    blk_t x;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) x[r][j] = 8'($urandom_range(0, 255));
    return x;
  endfunction

  task automatic send_row(input logic [7:0][7:0] row);
    int w = 0;
    in_row   = row;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check(1'b0, "in_ready_timeout", $sformatf("got in_ready=0 want 1 within %0d cycles", w));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rows_acc++;
    in_valid = 1'b0;
  endtask

  task automatic send_rows(input blk_t x, input int n);
    for (int r = 0; r < n; r++) send_row(x[r]);
  endtask

  task automatic collect(input res_t ex, input string name, output int lat);
    int w;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      w = 1;
      @(negedge clk);
      while (!(out_valid && out_ready) && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (c == 0) lat = w;
      if (!(out_valid && out_ready)) begin
        check(1'b0, $sformatf("%s_timeout", name), $sformatf("got out_valid=0 want 1 for column %0d", c));
        return;
      end
      check(out_col === ex[c] && out_idx == 3'(c) && out_last == (c == 7),
            $sformatf("%s_col%0d", name, c),
            $sformatf("got idx=%0d last=%0b col=%h want idx=%0d last=%0b col=%h",
                      out_idx, out_last, out_col, c, (c == 7), ex[c]));
      cap[c] = out_col;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    blk_t bp_x [3];
    res_t bp_y [3];
    blk_t rn_x [6];
    res_t rn_y [6];
    blk_t tmp_x;
    res_t tmp_y;
    res_t ex;
    logic [7:0][11:0] hold;
    int   lat, w, got, cyc;
    bit   stall;
    logic [7:0][11:0] pc;
    logic [2:0] pi;

    init_coefs();

    vecs[0].name = "zero";   vecs[0].x = '0; vecs[0].y = '0;
    vecs[1].name = "c127";   vecs[2].name = "cm128";
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        vecs[1].x[r][j] = 8'sd127;
        vecs[2].x[r][j] = -8'sd128;
      end
    vecs[1].y = '0; vecs[1].y[0][0] = 12'(1004);
    vecs[2].y = '0; vecs[2].y[0][0] = 12'(-1012);
    vecs[3].name = "impulse"; vecs[3].x = '0; vecs[3].x[0][0] = 8'sd100;
    vecs[3].y = ref_dct(vecs[3].x);
    for (int i = 4; i < 8; i++) begin
      vecs[i].name = $sformatf("rand%0d", i);
      vecs[i].x    = rand_blk();
      vecs[i].y    = ref_dct(vecs[i].x);
    end

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_row    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(out_valid == 1'b0, "rst_out_valid", $sformatf("got %0b want 0", out_valid));
    check(out_col == '0, "rst_out_col", $sformatf("got %h want 0", out_col));
    check(out_idx == 3'd0 && out_last == 1'b0, "rst_idx_last", $sformatf("got idx=%0d last=%0b want 0 0", out_idx, out_last));
    check(in_ready == 1'b0, "rst_in_ready", $sformatf("got %0b want 0", in_ready));
    rst = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b1, "post_rst_in_ready", $sformatf("got %0b want 1", in_ready));
    @(posedge clk);
    #1;

    // Directed and random vector table, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_rows(vecs[i].x, 8);
      collect(vecs[i].y, vecs[i].name, lat);
      if (i == 0) check(lat == 2, "first_latency", $sformatf("got %0d edges want 2", lat));
      if (i == 3) begin
        check(cap[0][0] == 12'd12, "impulse_y00", $sformatf("got %0d want 12", $signed(cap[0][0])));
        check(cap[0][1] == 12'd17, "impulse_y10", $sformatf("got %0d want 17", $signed(cap[0][1])));
      end
    end

    // Three blocks offered while the output is stalled.
    out_ready = 1'b0;
    rows_acc  = 0;
    for (int i = 0; i < 3; i++) begin
      bp_x[i] = rand_blk();
      bp_y[i] = ref_dct(bp_x[i]);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) send_rows(bp_x[i], 8);
      end
    join_none
    w = 0;
    while (rows_acc < 16 && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    check(rows_acc == 16, "bp_rows_accepted", $sformatf("got %0d want 16", rows_acc));
    check(in_ready == 1'b0, "bp_in_ready_low", $sformatf("got %0b want 0", in_ready));
    ex = bp_y[0];
    check(out_valid && out_idx == 3'd0 && out_col === ex[0], "bp_col0",
          $sformatf("got v=%0b idx=%0d col=%h want v=1 idx=0 col=%h", out_valid, out_idx, out_col, ex[0]));
    hold = out_col;
    repeat (3) @(negedge clk);
    check(out_valid && out_col === hold, "bp_col0_stable", $sformatf("got v=%0b col=%h want v=1 col=%h", out_valid, out_col, hold));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      w = 1;
      @(negedge clk);
      while (!out_valid && w < 500) begin
        @(negedge clk);
        w++;
      end
      ex = bp_y[n / 8];
      check(out_valid && out_col === ex[n % 8] && out_idx == 3'(n % 8),
            $sformatf("bp_beat%0d", n),
            $sformatf("got v=%0b idx=%0d col=%h want v=1 idx=%0d col=%h", out_valid, out_idx, out_col, n % 8, ex[n % 8]));
      if (n == 6) check(in_ready == 1'b0, "bp_in_ready_before", $sformatf("got %0b want 0", in_ready));
      if (n == 7) check(in_ready == 1'b1, "bp_in_ready_return", $sformatf("got %0b want 1", in_ready));
      @(posedge clk);
      #1;
    end

    // Randomized stream with random gaps and random back-pressure.
    for (int i = 0; i < 6; i++) begin
      rn_x[i] = rand_blk();
      rn_y[i] = ref_dct(rn_x[i]);
    end
    got   = 0;
    cyc   = 0;
    stall = 1'b0;
    pc    = '0;
    pi    = '0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            tmp_x = rn_x[i];
            send_row(tmp_x[r]);
          end
      end
      begin
        while (got < 48 && cyc < 5000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          cyc++;
          if (stall)
            check(out_valid && out_col === pc && out_idx == pi, "rnd_hold",
                  $sformatf("got v=%0b idx=%0d col=%h want v=1 idx=%0d col=%h", out_valid, out_idx, out_col, pi, pc));
          stall = out_valid && !out_ready;
          pc    = out_col;
          pi    = out_idx;
          if (out_valid && out_ready) begin
            tmp_y = rn_y[got / 8];
            check(out_col === tmp_y[got % 8] && out_idx == 3'(got % 8) && out_last == (got % 8 == 7),
                  $sformatf("rnd_beat%0d", got),
                  $sformatf("got idx=%0d last=%0b col=%h want idx=%0d last=%0b col=%h",
                            out_idx, out_last, out_col, got % 8, (got % 8 == 7), tmp_y[got % 8]));
            got++;
          end
        end
        check(got == 48, "rnd_count", $sformatf("got %0d columns want 48", got));
      end
    join
    @(posedge clk);
    #1;

    // Reset mid-output and mid-block; stale data must not leak afterwards.
    out_ready = 1'b0;
    send_rows(rand_blk(), 8);
    send_rows(rand_blk(), 4);
    @(negedge clk);
    check(out_valid == 1'b1, "pre_rst_valid", $sformatf("got %0b want 1", out_valid));
    rst = 1'b0;
    #1;
    check(out_valid == 1'b0 && out_col == '0 && out_idx == 3'd0 && out_last == 1'b0, "midrst_outputs",
          $sformatf("got v=%0b col=%h idx=%0d last=%0b want all 0", out_valid, out_col, out_idx, out_last));
    check(in_ready == 1'b0, "midrst_in_ready", $sformatf("got %0b want 0", in_ready));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(in_ready == 1'b1 && out_valid == 1'b0, "post_midrst",
          $sformatf("got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tmp_x = rand_blk();
    send_rows(tmp_x, 8);
    collect(ref_dct(tmp_x), "after_rst", lat);
    check(lat == 2, "after_rst_latency", $sformatf("got %0d edges want 2", lat));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
